// File: rtl/mont_exp_engine_pkg.sv
// Shared types and width helpers for the modular-exponentiation engine.
// Exports: state_t (engine FSM encoding), cnt_w()/eidx_w() counter width helpers.
// No ports; imported by mont_mul and mont_exp_engine.
package mont_exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PREP,
    LOOP,
    DONE
  } state_t;

  // Counter wide enough for WIDTH+2 cycles of a Montgomery multiply.
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

  // Exponent bit index / length counter, must hold the value EXP_W itself.
  function automatic int eidx_w(input int exp_w);
    return $clog2(exp_w + 1);
  endfunction

endpackage

// File: rtl/mont_mul.sv
// Bit-serial Montgomery multiplier: result = x*y*2^-WIDTH mod n, for x,y < n, n odd.
// Ports: clk/rst_n, start (clears accumulator, latches x), x/y/n operands,
//        result (held until next start), done (1-cycle pulse, WIDTH+1 cycles after start).
module mont_mul
  import mont_exp_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  logic [WIDTH+1:0] acc_q;
  logic [WIDTH+1:0] sum_y;
  logic [WIDTH+1:0] sum_n;
  logic [WIDTH+1:0] half;
  logic [WIDTH+1:0] acc_d;
  logic [WIDTH-1:0] x_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             last;

  // acc stays below 2n, so acc+y < 3n and +n < 4n: WIDTH+2 bits never overflow.
  always_comb begin
    sum_y = acc_q + (x_q[0] ? {2'b00, y} : '0);
    sum_n = sum_y + (sum_y[0] ? {2'b00, n} : '0);
    half  = sum_n >> 1;
    last  = (cnt_q == LAST_IT);
    acc_d = half;
    if (last && (half >= {2'b00, n})) begin
      acc_d = half - {2'b00, n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      x_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_q <= '0;
        x_q   <= x;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        acc_q <= acc_d;
        x_q   <= x_q >> 1;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign result = acc_q[WIDTH-1:0];

endmodule

// File: rtl/mont_exp_engine.sv
// Modular exponentiation o_result = i_base^i_exp mod i_mod, right-to-left square-and-multiply.
// Ports: i_clk/i_rst_n, i_start + operands (latched on acceptance), o_busy,
//        o_valid/i_out_ready result handshake, o_result, o_error (illegal operands).
module mont_exp_engine
  import mont_exp_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int EXP_W = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_base,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [WIDTH-1:0] i_mod,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_error
);

  localparam int CNT_W  = cnt_w(WIDTH);
  localparam int EIDX_W = eidx_w(EXP_W);
  localparam logic [CNT_W-1:0] PREP_LAST = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mod_q, t_q, m_q;
  logic [EXP_W-1:0]  exp_q, e_sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [EIDX_W-1:0] idx_q, k;
  logic              bit_start_q, err_q;

  logic              illegal, prep_last, last_bit;
  logic [WIDTH:0]    t_dbl;
  logic [WIDTH-1:0]  t_next;
  logic              sq_start, mul_start, sq_done, mul_done, bit_done, handshake;
  logic [WIDTH-1:0]  sq_res, mul_res;

  // Exponent length: index of highest set bit plus one (0 when exponent is 0).
  always_comb begin
    k = '0;
    for (int b = 0; b < EXP_W; b++) begin
      if (exp_q[b]) k = EIDX_W'(b + 1);
    end
  end

  // t_q holds the latched base during CHECK.
  assign illegal   = ~mod_q[0] | (mod_q == WIDTH'(1)) | (t_q >= mod_q);
  assign prep_last = (cnt_q == PREP_LAST);
  assign last_bit  = ((idx_q + 1'b1) == k);

  // Doubling step of the conversion into the Montgomery domain; t < N keeps the result < N.
  always_comb begin
    t_dbl  = {t_q, 1'b0};
    t_next = WIDTH'((t_dbl >= {1'b0, mod_q}) ? (t_dbl - {1'b0, mod_q}) : t_dbl);
  end

  assign sq_start  = (state_q == LOOP) & bit_start_q;
  assign mul_start = sq_start & e_sh_q[0];
  // Both units start together and finish together; the multiply only gates when it ran.
  assign bit_done  = sq_done & (mul_done | ~e_sh_q[0]);
  assign handshake = (state_q == DONE) & o_valid & i_out_ready;
  assign o_busy    = (state_q != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (i_start) state_d = CHECK;
      CHECK: state_d = illegal ? DONE : PREP;
      PREP:  if (prep_last) state_d = (k == '0) ? DONE : LOOP;
      LOOP:  if (bit_done && last_bit) state_d = DONE;
      DONE:  if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mod_q       <= '0;
      t_q         <= '0;
      m_q         <= '0;
      exp_q       <= '0;
      e_sh_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      bit_start_q <= 1'b0;
      err_q       <= 1'b0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_error     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            mod_q       <= i_mod;
            t_q         <= i_base;
            exp_q       <= i_exp;
            e_sh_q      <= i_exp;
            cnt_q       <= '0;
            bit_start_q <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        CHECK: begin
          err_q <= illegal;
          m_q   <= WIDTH'(1);
          cnt_q <= '0;
        end
        PREP: begin
          t_q   <= t_next;
          cnt_q <= cnt_q + 1'b1;
          if (prep_last) begin
            idx_q       <= '0;
            bit_start_q <= 1'b1;
          end
        end
        LOOP: begin
          if (sq_start) bit_start_q <= 1'b0;
          if (bit_done) begin
            t_q <= sq_res;
            if (e_sh_q[0]) m_q <= mul_res;
            e_sh_q      <= e_sh_q >> 1;
            idx_q       <= idx_q + 1'b1;
            bit_start_q <= 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; it is then frozen until taken.
          if (!o_valid) begin
            o_valid  <= 1'b1;
            o_error  <= err_q;
            o_result <= err_q ? '0 : m_q;
          end else if (i_out_ready) begin
            o_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Squarer keeps t in the Montgomery domain; m*t with m plain yields a plain m.
  mont_mul #(.WIDTH(WIDTH)) u_sq (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (sq_start),
    .x      (t_q),
    .y      (t_q),
    .n      (mod_q),
    .result (sq_res),
    .done   (sq_done)
  );

  mont_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (mul_start),
    .x      (m_q),
    .y      (t_q),
    .n      (mod_q),
    .result (mul_res),
    .done   (mul_done)
  );

endmodule
